// File: rtl/blink_seq_ctrl.sv
// Run/pause/sweep controller for the LED blink engine: selects manual speed
// control or an automatic 0->3->0 ping-pong sweep with a programmable dwell.
//
// state  | meaning
// IDLE   | blinker off, waiting for START
// MANUAL | blinker on, speed driven by UP/DOWN pulses
// SWEEP  | blinker on, speed stepped automatically every dwell period
// PAUSE  | blinker off, counters and speed frozen until START
module blink_seq_ctrl #(
    parameter int DIV_W       = 25,
    parameter int DWELL_TICKS = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       STOP,
    input  logic       AUTO,
    input  logic       UP,
    input  logic       DOWN,
    output logic [1:0] SPEED,
    output logic       LEDEN,
    output logic [1:0] STATE,
    output logic       STEP
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SWEEP  = 2'd2,
        ST_PAUSE  = 2'd3
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL_TICKS - 1);

    state_t             state_q, state_d;
    logic [1:0]         speed_q, speed_d;
    logic               leden_q, leden_d;
    logic               step_q, step_d;
    logic [DIV_W-1:0]   presc_q, presc_d;
    logic [7:0]         dwell_q, dwell_d;
    logic               dir_up_q, dir_up_d;
    logic               was_sweep_q, was_sweep_d;

    always_comb begin
        state_d     = state_q;
        speed_d     = speed_q;
        step_d      = 1'b0;
        presc_d     = presc_q;
        dwell_d     = dwell_q;
        dir_up_d    = dir_up_q;
        was_sweep_d = was_sweep_q;

        case (state_q)
            ST_IDLE: begin
                if (START && !STOP) begin
                    if (AUTO) begin
                        state_d  = ST_SWEEP;
                        presc_d  = '0;
                        dwell_d  = 8'd0;
                        dir_up_d = 1'b1;
                    end else begin
                        state_d = ST_MANUAL;
                    end
                end
            end
            ST_MANUAL: begin
                if (STOP) begin
                    state_d = ST_IDLE;
                end else if (START) begin
                    state_d     = ST_PAUSE;
                    was_sweep_d = 1'b0;
                end else if (AUTO) begin
                    state_d  = ST_SWEEP;
                    presc_d  = '0;
                    dwell_d  = 8'd0;
                    dir_up_d = 1'b1;
                end else if (UP) begin
                    if (speed_q != 2'd3) speed_d = speed_q + 2'd1;
                end else if (DOWN) begin
                    if (speed_q != 2'd0) speed_d = speed_q - 2'd1;
                end
            end
            ST_SWEEP: begin
                if (STOP) begin
                    state_d = ST_IDLE;
                end else begin
                    // Counting continues on the pausing edge; leaving for MANUAL does not count.
                    if (AUTO) begin
                        presc_d = presc_q + DIV_W'(1);
                        if (&presc_q) begin
                            if (dwell_q == DWELL_LAST) begin
                                dwell_d = 8'd0;
                                step_d  = 1'b1;
                                if (dir_up_q) begin
                                    if (speed_q == 2'd3) begin
                                        speed_d  = 2'd2;
                                        dir_up_d = 1'b0;
                                    end else begin
                                        speed_d = speed_q + 2'd1;
                                    end
                                end else begin
                                    if (speed_q == 2'd0) begin
                                        speed_d  = 2'd1;
                                        dir_up_d = 1'b1;
                                    end else begin
                                        speed_d = speed_q - 2'd1;
                                    end
                                end
                            end else begin
                                dwell_d = dwell_q + 8'd1;
                            end
                        end
                    end
                    if (START) begin
                        state_d     = ST_PAUSE;
                        was_sweep_d = 1'b1;
                    end else if (!AUTO) begin
                        state_d = ST_MANUAL;
                    end
                end
            end
            ST_PAUSE: begin
                if (STOP) begin
                    state_d = ST_IDLE;
                end else if (START) begin
                    if (AUTO) begin
                        state_d = ST_SWEEP;
                        if (!was_sweep_q) begin
                            presc_d  = '0;
                            dwell_d  = 8'd0;
                            dir_up_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_MANUAL;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        leden_d = (state_d == ST_MANUAL) || (state_d == ST_SWEEP);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            speed_q     <= 2'd0;
            leden_q     <= 1'b0;
            step_q      <= 1'b0;
            presc_q     <= '0;
            dwell_q     <= 8'd0;
            dir_up_q    <= 1'b1;
            was_sweep_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            speed_q     <= speed_d;
            leden_q     <= leden_d;
            step_q      <= step_d;
            presc_q     <= presc_d;
            dwell_q     <= dwell_d;
            dir_up_q    <= dir_up_d;
            was_sweep_q <= was_sweep_d;
        end
    end

    assign SPEED = speed_q;
    assign LEDEN = leden_q;
    assign STATE = state_q;
    assign STEP  = step_q;

endmodule

// File: doc/blink_seq_ctrl.md
# blink_seq_ctrl

Run/pause/sweep controller for the LED blink datapath. It decides when the blinker is enabled and which of the four speed settings it uses. It consumes debounced single-cycle button pulses and drives `SPEED[1:0]` and `LEDEN` into the blink engine. In manual mode the speed follows UP/DOWN; in auto mode the controller sweeps the speed 0→3→0 on its own, dwelling a programmable time at each step.

## Interface
- `DIV_W`, default 25: prescaler width; one dwell tick every 2^DIV_W clocks.
- `DWELL_TICKS`, default 4: dwell ticks per auto-sweep speed step; legal range 1..255.
- `CLK`  in  1: system clock; all logic on the rising edge.
- `RST`  in  1: reset, synchronous, active-high.
- `START`  in  1: debounced one-cycle pulse; start, pause or resume.
- `STOP`  in  1: debounced one-cycle pulse; return to idle.
- `AUTO`  in  1: level; 1 selects auto sweep, 0 selects manual.
- `UP`  in  1: debounced one-cycle pulse; speed +1 in manual run.
- `DOWN`  in  1: debounced one-cycle pulse; speed −1 in manual run.
- `SPEED`  out  2: speed setting to the blink engine; 0 is slowest, 3 is fastest.
- `LEDEN`  out  1: blink engine enable; high only in MANUAL or SWEEP.
- `STATE`  out  2: current state encoding, for status display.
- `STEP`  out  1: one-cycle pulse on each auto-sweep speed change.

## Operation
- States and encodings: IDLE=0, MANUAL=1, SWEEP=2, PAUSE=3.
- IDLE
  - START moves to MANUAL if AUTO=0, otherwise to SWEEP.
  - Entry to SWEEP from IDLE clears the prescaler and dwell counters and sets the sweep direction to up.
- MANUAL
  - UP: SPEED+1, saturating at 3. DOWN: SPEED−1, saturating at 0.
  - UP has priority when UP and DOWN arrive in the same cycle.
  - AUTO=1 moves to SWEEP: prescaler and dwell counters clear, direction goes up, SPEED is retained.
  - START moves to PAUSE.
- SWEEP
  - The prescaler runs; a tick fires when it is all ones.
  - The dwell counter counts ticks. On the tick where dwell = DWELL_TICKS−1: dwell returns to 0, SPEED steps in the current direction, and STEP pulses.
  - Ping-pong direction: if up and SPEED=3, the step goes to 2 and direction becomes down. If down and SPEED=0, the step goes to 1 and direction becomes up.
  - UP and DOWN are ignored.
  - AUTO=0 moves to MANUAL with SPEED retained.
  - START moves to PAUSE.
- PAUSE
  - LEDEN is 0. Prescaler, dwell counter, direction and SPEED are frozen. UP and DOWN are ignored.
  - START resumes to MANUAL if AUTO=0, otherwise to SWEEP. Frozen counters are kept only when the resumed mode is SWEEP and the pre-pause mode was also SWEEP; any other resume to SWEEP clears them.
- STOP in any non-IDLE state moves to IDLE. SPEED is retained. Counters clear on the next SWEEP entry.
- STOP beats START in the same cycle. STOP in IDLE has no effect.
- The controller needs a one-bit record of the pre-pause mode.

## Timing
- All outputs are registered.
- Reset values: SPEED=0, LEDEN=0, STATE=0 (IDLE), STEP=0. Internal reset values: prescaler=0, dwell=0, direction=up.
- RST asserted mid-operation returns everything to the reset values on the next edge, overriding all inputs.
- A control pulse sampled at edge n is reflected in STATE, LEDEN and SPEED after edge n, i.e. one cycle of latency.
- An AUTO level change has the same one-cycle latency.
- STEP is high for exactly one cycle, the cycle in which the new SPEED first appears.
- Sweep timing from SWEEP entry with cleared counters: the first step occurs DWELL_TICKS·2^DIV_W clocks after the entry edge. Steps then repeat every DWELL_TICKS·2^DIV_W clocks.
- The prescaler and dwell counter wrap naturally. Dwell is 8 bits wide, compared against DWELL_TICKS−1.
- A pulse longer than one cycle is treated as one event per cycle high. Upstream debouncing guarantees single-cycle pulses; this block does no edge detection.

## Test plan
All scenarios use DIV_W=2 and DWELL_TICKS=2, so one step every 8 clocks.
- Reset, then START with AUTO=0, then 5× UP, then 5× DOWN → STATE=1, LEDEN=1. SPEED goes 1,2,3,3,3, then 2,1,0,0,0.
- In MANUAL, UP and DOWN in the same cycle → SPEED +1. START → STATE=3, LEDEN=0, and a following UP is ignored. START again → STATE=1 with SPEED unchanged.
- START with AUTO=1 from IDLE → STATE=2. STEP pulses at clocks 8, 16, 24, …. SPEED follows 1,2,3,2,1,0,1.
- In SWEEP, pause at clock 12 for 20 clocks, then resume → next STEP at resume+4.
- In SWEEP, drop AUTO → STATE=1 with SPEED held. Raise AUTO → first STEP 8 clocks later, direction up.
- STOP and START in the same cycle → STATE=0, LEDEN=0. RST asserted in SWEEP → all outputs return to reset values on the next edge.
